// File: rtl/fht_frame_ctrl.sv
// rtl/fht_frame_ctrl.sv - frame sequencer: load samples into FHT RAM, start transform, unload results
//
// Ports:
//   iCLK, iRESET                 clock, synchronous active-low reset
//   iDATA/iVALID/oREADY          input sample stream
//   oWE/oADDR_WR/oDATA_WR        buffer RAM write port (registered)
//   oADDR_RD/iDATA_RD            buffer RAM read port, 1-cycle read latency
//   oFHT_START/iFHT_RDY          handshake with the FHT control block
//   oDATA/oVALID/iREADY          result sample stream
//   oBUSY                        high whenever a frame is in progress
module fht_frame_ctrl #(
    parameter int N      = 256,
    parameter int A_BIT  = 8,
    parameter int D_BIT  = 16,
    parameter int BITREV = 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic             oWE,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA_WR,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iDATA_RD,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oBUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_UNLOAD
    } state_t;

    localparam logic [A_BIT-1:0] LAST = A_BIT'(N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [A_BIT-1:0] cnt;
    logic             xfer;
    logic             pop;
    logic             last_pop;
    logic             rd_issue;
    logic             rd_pend;
    logic             rd_done;
    logic [D_BIT-1:0] sk_mem [2];
    logic             sk_wr_ptr;
    logic             sk_rd_ptr;
    logic [1:0]       sk_cnt;
    logic [1:0]       sk_occ_after;

    function automatic logic [A_BIT-1:0] bit_reverse(input logic [A_BIT-1:0] a);
        logic [A_BIT-1:0] r;
        r = '0;
        for (int i = 0; i < A_BIT; i++) begin
            r[i] = a[A_BIT-1-i];
        end
        return r;
    endfunction

    // Gated by reset so nothing is accepted on the reset edge itself.
    assign oREADY   = iRESET && ((state == S_IDLE) || (state == S_LOAD));
    assign xfer     = iVALID && oREADY;
    assign oBUSY    = (state != S_IDLE);
    assign oVALID   = (sk_cnt != 2'd0);
    assign oDATA    = sk_mem[sk_rd_ptr];
    assign pop      = oVALID && iREADY;
    // cnt doubles as the output counter during unload (it wrapped to 0 after load).
    assign last_pop = pop && (cnt == LAST);

    // Skid occupancy once this cycle's in-flight read lands and any pop retires;
    // a new read may only be issued if that still leaves a free entry.
    assign sk_occ_after = sk_cnt + {1'b0, rd_pend} - {1'b0, pop};

    // Address 0 is already on oADDR_RD while waiting, so the first read goes out
    // on the same edge that sees the transform finish.
    assign rd_issue = !rd_done &&
                      (((state == S_WAIT_HIGH) && iFHT_RDY) ||
                       ((state == S_UNLOAD) && (sk_occ_after < 2'd2)));

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (xfer) state_nxt = S_LOAD;
            S_LOAD:      if (xfer && (cnt == LAST)) state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_LOW;
            S_WAIT_LOW:  if (!iFHT_RDY) state_nxt = S_WAIT_HIGH;
            S_WAIT_HIGH: if (iFHT_RDY) state_nxt = S_UNLOAD;
            S_UNLOAD:    if (last_pop) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            cnt        <= '0;
            oWE        <= 1'b0;
            oADDR_WR   <= '0;
            oDATA_WR   <= '0;
            oADDR_RD   <= '0;
            oFHT_START <= 1'b0;
            rd_pend    <= 1'b0;
            rd_done    <= 1'b0;
            sk_mem[0]  <= '0;
            sk_mem[1]  <= '0;
            sk_wr_ptr  <= 1'b0;
            sk_rd_ptr  <= 1'b0;
            sk_cnt     <= 2'd0;
        end else begin
            oWE <= xfer;
            if (xfer) begin
                oDATA_WR <= iDATA;
                oADDR_WR <= (BITREV != 0) ? bit_reverse(cnt) : cnt;
            end
            if (xfer || pop) begin
                cnt <= cnt + 1'b1;
            end

            // Registered from START so the pulse lands after the last write strobe.
            oFHT_START <= (state == S_START);

            rd_pend <= rd_issue;
            if (rd_issue) begin
                oADDR_RD <= oADDR_RD + 1'b1;
            end
            if (last_pop) begin
                rd_done <= 1'b0;
            end else if (rd_issue && (oADDR_RD == LAST)) begin
                rd_done <= 1'b1;
            end

            if (rd_pend) begin
                sk_mem[sk_wr_ptr] <= iDATA_RD;
                sk_wr_ptr         <= ~sk_wr_ptr;
            end
            if (pop) begin
                sk_rd_ptr <= ~sk_rd_ptr;
            end
            sk_cnt <= sk_cnt + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fht_frame_ctrl.sv
// tb/tb_fht_frame_ctrl.sv - directed self-checking bench for fht_frame_ctrl (N=8)
module tb_fht_frame_ctrl;

    localparam logic [2:0] EXP_BR [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    logic        clk;
    logic        resetn;
    logic [15:0] in_data;
    logic        in_valid;
    logic        ds_ready;
    logic        fht_rdy;
    logic [15:0] ram_rd;

    logic        ready, we, fht_start, out_valid, busy;
    logic [2:0]  addr_wr, addr_rd;
    logic [15:0] data_wr, out_data;

    logic        ready0, we0, fht_start0, out_valid0, busy0;
    logic [2:0]  addr_wr0, addr_rd0;
    logic [15:0] data_wr0, out_data0;

    logic [15:0] ram [8];
    logic        fht_fill;
    logic [15:0] fill_base;

    int checks = 0;
    int failures = 0;
    int nstart = 0;
    int overlap = 0;
    int lockstep = 0;
    bit mon_en = 0;

    fht_frame_ctrl #(.N(8), .A_BIT(3), .D_BIT(16), .BITREV(1)) dut (
        .iCLK(clk), .iRESET(resetn), .iDATA(in_data), .iVALID(in_valid), .oREADY(ready),
        .oWE(we), .oADDR_WR(addr_wr), .oDATA_WR(data_wr), .oADDR_RD(addr_rd), .iDATA_RD(ram_rd),
        .oFHT_START(fht_start), .iFHT_RDY(fht_rdy), .oDATA(out_data), .oVALID(out_valid),
        .iREADY(ds_ready), .oBUSY(busy)
    );

    fht_frame_ctrl #(.N(8), .A_BIT(3), .D_BIT(16), .BITREV(0)) dut0 (
        .iCLK(clk), .iRESET(resetn), .iDATA(in_data), .iVALID(in_valid), .oREADY(ready0),
        .oWE(we0), .oADDR_WR(addr_wr0), .oDATA_WR(data_wr0), .oADDR_RD(addr_rd0), .iDATA_RD(ram_rd),
        .oFHT_START(fht_start0), .iFHT_RDY(fht_rdy), .oDATA(out_data0), .oVALID(out_valid0),
        .iREADY(ds_ready), .oBUSY(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fht_fill) begin
            for (int i = 0; i < 8; i++) ram[i] <= fill_base + 16'(i);
        end else if (we === 1'b1) begin
            ram[addr_wr] <= data_wr;
        end
        ram_rd <= ram[addr_rd];
    end

    always @(posedge clk) begin
        if (fht_start === 1'b1) nstart <= nstart + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if ((we & fht_start) | (we & out_valid) | (fht_start & out_valid)) overlap <= overlap + 1;
            if (ready0 !== ready || busy0 !== busy || fht_start0 !== fht_start ||
                out_valid0 !== out_valid || addr_rd0 !== addr_rd || we0 !== we ||
                (out_valid && out_data0 !== out_data))
                lockstep <= lockstep + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({we, fht_start, out_valid, busy, ready} !== 5'b0)
            begin failures++; $display("FAIL reset_flags: we/start/valid/busy/ready=%b need 00000", {we, fht_start, out_valid, busy, ready}); end
        checks++;
        if (addr_wr !== 3'd0 || addr_rd !== 3'd0 || data_wr !== 16'd0 || out_data !== 16'd0)
            begin failures++; $display("FAIL reset_data: addr_wr=%0d addr_rd=%0d data_wr=%0d data=%0d need all 0", addr_wr, addr_rd, data_wr, out_data); end
        resetn = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: ready=%b need 1", ready); end
        mon_en = 1'b1;
    endtask

    task automatic load_frame(input logic [15:0] base);
        int rdy_bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready !== 1'b1) rdy_bad++;
            in_valid = 1'b1;
            in_data  = base + 16'(i);
            tick();
            checks++;
            if (we !== 1'b1 || addr_wr !== EXP_BR[i] || data_wr !== base + 16'(i))
                begin failures++; $display("FAIL load_bitrev[%0d]: we=%b addr=%0d data=%0d need we=1 addr=%0d data=%0d", i, we, addr_wr, data_wr, EXP_BR[i], base + 16'(i)); end
            checks++;
            if (we0 !== 1'b1 || addr_wr0 !== 3'(i) || data_wr0 !== base + 16'(i))
                begin failures++; $display("FAIL load_natural[%0d]: we=%b addr=%0d data=%0d need we=1 addr=%0d data=%0d", i, we0, addr_wr0, data_wr0, i, base + 16'(i)); end
            checks++;
            if (fht_start !== 1'b0) begin failures++; $display("FAIL start_early[%0d]: start=%b need 0", i, fht_start); end
        end
        in_valid = 1'b0;
        checks++;
        if (rdy_bad != 0) begin failures++; $display("FAIL load_ready: %0d cycles with ready low, need 0", rdy_bad); end
        tick();
        checks++;
        if (fht_start !== 1'b1 || we !== 1'b0)
            begin failures++; $display("FAIL start_pulse: start=%b we=%b need start=1 we=0", fht_start, we); end
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL ready_after_load: ready=%b need 0", ready); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ram[EXP_BR[i]] !== base + 16'(i))
                begin failures++; $display("FAIL ram_content[%0d]: got %0d need %0d", EXP_BR[i], ram[EXP_BR[i]], base + 16'(i)); end
        end
        tick();
        checks++;
        if (fht_start !== 1'b0) begin failures++; $display("FAIL start_width: start=%b need 0", fht_start); end
    endtask

    task automatic unload_check(input int mode, input logic [15:0] base, input bit hold);
        int got = 0;
        int cyc = 0;
        int first = -1;
        int bad = 0;
        bit stalled = 1'b0;
        logic [15:0] held = '0;
        while (got < 8 && cyc < 200) begin
            in_valid = hold;
            if (we !== 1'b0 || ready !== 1'b0) bad++;
            if (stalled && (out_valid !== 1'b1 || out_data !== held)) bad++;
            ds_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                if (ds_ready) begin
                    checks++;
                    if (out_data !== base + 16'(got))
                        begin failures++; $display("FAIL out_data[%0d]: got %0d need %0d", got, out_data, base + 16'(got)); end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        ds_ready = 1'b0;
        checks++;
        if (got != 8) begin failures++; $display("FAIL unload_count: got %0d outputs need 8", got); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL unload_stability: %0d bad cycles need 0", bad); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL unload_end: valid=%b busy=%b need 0 0", out_valid, busy); end
        if (mode == 0) begin
            checks++;
            if (first != 2) begin failures++; $display("FAIL first_valid_latency: %0d cycles need 2", first); end
            checks++;
            if (cyc - first != 8) begin failures++; $display("FAIL unload_bubble: %0d cycles need 8", cyc - first); end
        end
    endtask

    task automatic fht_run(input logic [15:0] ofs, input int mode, input bit hold);
        int bad = 0;
        in_valid = hold;
        tick();
        fht_rdy   = 1'b0;
        fill_base = ofs;
        fht_fill  = 1'b1;
        tick();
        fht_fill = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (we !== 1'b0 || ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wait_idle_outputs: %0d bad cycles need 0", bad); end
        fht_rdy = 1'b1;
        unload_check(mode, ofs, hold);
    endtask

    task automatic test_load_unload;
        load_frame(16'd10);
        fht_run(16'd100, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        load_frame(16'd20);
        fht_run(16'd200, 1, 1'b0);
    endtask

    task automatic test_ignore_valid;
        load_frame(16'd30);
        fht_run(16'd300, 0, 1'b1);
    endtask

    task automatic test_back_to_back;
        load_frame(16'd40);
        fht_run(16'd400, 0, 1'b0);
        load_frame(16'd50);
        fht_run(16'd500, 1, 1'b0);
    endtask

    task automatic test_mid_reset;
        int snap;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(70 + i);
            tick();
        end
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready: ready=%b need 0", ready); end
        tick();
        checks++;
        if ({we, fht_start, out_valid, busy} !== 4'b0)
            begin failures++; $display("FAIL mid_reset_flags: we/start/valid/busy=%b need 0000", {we, fht_start, out_valid, busy}); end
        checks++;
        if (addr_wr !== 3'd0 || addr_rd !== 3'd0 || data_wr !== 16'd0 || out_data !== 16'd0)
            begin failures++; $display("FAIL mid_reset_data: addr_wr=%0d addr_rd=%0d data_wr=%0d data=%0d need all 0", addr_wr, addr_rd, data_wr, out_data); end
        resetn = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL mid_reset_release: ready=%b need 1", ready); end
        snap = nstart;
        load_frame(16'd60);
        fht_run(16'd600, 0, 1'b0);
        checks++;
        if (nstart - snap != 1) begin failures++; $display("FAIL start_count: %0d pulses need 1", nstart - snap); end
    endtask

    initial begin
        resetn    = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        ds_ready  = 1'b0;
        fht_rdy   = 1'b1;
        fht_fill  = 1'b0;
        fill_base = '0;
        test_reset();
        test_load_unload();
        test_backpressure();
        test_ignore_valid();
        test_back_to_back();
        test_mid_reset();
        tick();
        checks++;
        if (overlap != 0) begin failures++; $display("FAIL strobe_overlap: %0d cycles need 0", overlap); end
        checks++;
        if (lockstep != 0) begin failures++; $display("FAIL bitrev_lockstep: %0d cycles differ need 0", lockstep); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
